// File: rtl/memarb_pkg.sv
// memarb_pkg: shared state encoding, abort data and bus widths for mem_bus_arbiter
package memarb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [DATA_W-1:0] MEMARB_ABORT_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;
endpackage

// File: rtl/memarb_rr.sv
// memarb_rr: picks the next owner from the two requests, round-robin or m0-priority
module memarb_rr #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] next_grant
);
  // a tie goes to whoever did not finish last (round-robin) or to m0 (fixed)
  always_comb next_grant = &req ? ((ROUND_ROBIN && !last_grant) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master picorv32-style bus arbiter; MEMARB_TIMEOUT_EN adds a hung-transaction watchdog
module mem_bus_arbiter
  import memarb_pkg::*;
#(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_flag,
  input  logic              timeout_clr
);
  state_t     state, state_nxt;
  logic       last_grant;
  logic [1:0] req_grant;
  logic       busy, sel1, own_valid, fwd, done, abort;

  memarb_rr #(.ROUND_ROBIN(ROUND_ROBIN)) u_rr (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant),
    .next_grant (req_grant)
  );

  // owner tracking and next state: a transaction ends on completion, abort or the owner dropping valid
  always_comb begin
    busy      = state != IDLE;
    sel1      = state == BUSY1;
    own_valid = sel1 ? m1_valid : m0_valid;
    fwd       = busy & own_valid;
    done      = fwd & s_ready;
    state_nxt = busy ? ((done | abort | !own_valid) ? IDLE : state)
                     : (req_grant[0] ? BUSY0 : req_grant[1] ? BUSY1 : IDLE);
  end

  assign s_valid  = fwd & ~abort;
  assign s_instr  = busy & (sel1 ? m1_instr : m0_instr);
  assign s_addr   = busy ? (sel1 ? m1_addr : m0_addr) : '0;
  assign s_wdata  = busy ? (sel1 ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb  = busy ? (sel1 ? m1_wstrb : m0_wstrb) : '0;
  assign m0_ready = (state == BUSY0) & (done | abort);
  assign m1_ready = sel1 & (done | abort);
  assign m0_rdata = (!sel1 && abort) ? MEMARB_ABORT_DATA : s_rdata;
  assign m1_rdata = (sel1 && abort) ? MEMARB_ABORT_DATA : s_rdata;

  // FSM with registered grant; last_grant only moves when a transaction really finishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
    end else begin
      state <= state_nxt;
      grant <= {state_nxt == BUSY1, state_nxt == BUSY0};
      if (done | abort) last_grant <= sel1;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign abort = fwd & ~s_ready & (cnt == 16'(TIMEOUT_CYCLES - 1));
  // watchdog counts BUSY cycles from entry; the clear request beats a same-cycle abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt          <= busy ? cnt + 16'd1 : 16'd0;
      timeout_flag <= timeout_clr ? 1'b0 : (abort | timeout_flag);
    end
  end
`else
  logic unused_cfg;
  assign abort        = 1'b0;
  assign timeout_flag = 1'b0;
  assign unused_cfg   = timeout_clr ^ (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of mem_bus_arbiter (round-robin and fixed-priority instances)
module tb_mem_bus_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, s_rdata = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic s_ready = 0, timeout_clr = 0;
  logic m0_ready, m1_ready, s_valid, s_instr, timeout_flag;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic [1:0] grant;
  logic f_m0_ready, f_m1_ready, f_s_valid, f_s_instr, f_timeout_flag;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic [3:0] f_s_wstrb;
  logic [1:0] f_grant;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) u_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  mem_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8)) u_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
    .s_valid(f_s_valid), .s_instr(f_s_instr), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_wstrb(f_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(f_grant), .timeout_flag(f_timeout_flag), .timeout_clr(timeout_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_seq [7];
    logic [1:0] fp_seq [7];
    rr_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    fp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_m0_ready", 32'(m0_ready), 32'h0);
    check("rst_flag", 32'(timeout_flag), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    m0_valid = 1; m0_addr = 32'h0010_0000; s_rdata = 32'hCAFE_0001;
    #1;
    check("rd_idle_s_valid", 32'(s_valid), 32'h0);
    check("rd_idle_s_addr", s_addr, 32'h0);
    tick();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_s_valid", 32'(s_valid), 32'h1);
    check("rd_s_addr", s_addr, 32'h0010_0000);
    check("rd_m0_ready_wait", 32'(m0_ready), 32'h0);
    tick();
    tick();
    check("rd_s_addr_hold", s_addr, 32'h0010_0000);
    s_ready = 1;
    #1;
    check("rd_m0_ready", 32'(m0_ready), 32'h1);
    check("rd_m0_rdata", m0_rdata, 32'hCAFE_0001);
    check("rd_m1_ready", 32'(m1_ready), 32'h0);
    tick();
    m0_valid = 0; s_ready = 0;
    #1;
    check("rd_idle_grant", 32'(grant), 32'h0);
    check("rd_ready_pulse", 32'(m0_ready), 32'h0);

    #1 reset = 1'b1;
    #1 reset = 1'b0;
    m0_valid = 1; m1_valid = 1; s_ready = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("rr_grant_%0d", i), 32'(grant), 32'(rr_seq[i]));
      check($sformatf("fp_grant_%0d", i), 32'(f_grant), 32'(fp_seq[i]));
    end
    m0_valid = 0;
    #1;
    check("fp_drop_no_ready", 32'(f_m0_ready), 32'h0);
    tick();
    check("fp_drop_idle", 32'(f_grant), 32'h0);
    tick();
    check("fp_m1_granted", 32'(f_grant), 32'h2);
    m1_valid = 0; s_ready = 0;
    tick();
    check("rr_end_idle", 32'(grant), 32'h0);
    check("fp_end_idle", 32'(f_grant), 32'h0);

    m1_valid = 1; m1_addr = 32'h0300_0000; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    s_rdata = 32'h0BAD_F00D;
    tick();
    check("wr_grant", 32'(grant), 32'h2);
    check("wr_s_valid", 32'(s_valid), 32'h1);
    check("wr_s_addr", s_addr, 32'h0300_0000);
    check("wr_s_wdata", s_wdata, 32'h1234_5678);
    check("wr_s_wstrb", 32'(s_wstrb), 32'h3);
    check("wr_m0_ready_wait", 32'(m0_ready), 32'h0);
    tick();
    check("wr_m1_ready_wait", 32'(m1_ready), 32'h0);
    s_ready = 1;
    #1;
    check("wr_m1_ready", 32'(m1_ready), 32'h1);
    check("wr_m0_ready", 32'(m0_ready), 32'h0);
    check("wr_m1_rdata", m1_rdata, 32'h0BAD_F00D);
    m1_valid = 0; m1_wstrb = 0;
    tick();
    s_ready = 0;
    check("wr_done_grant", 32'(grant), 32'h0);

    m0_valid = 1;
`ifdef MEMARB_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("wd_wait_%0d", i), 32'(m0_ready), 32'h0);
    end
    tick();
    check("wd_m0_ready", 32'(m0_ready), 32'h1);
    check("wd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("wd_s_valid", 32'(s_valid), 32'h0);
    tick();
    m0_valid = 0;
    check("wd_flag", 32'(timeout_flag), 32'h1);
    check("wd_idle", 32'(grant), 32'h0);
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    check("wd_clr", 32'(timeout_flag), 32'h0);
`else
    for (int i = 0; i < 20; i++) tick();
    check("nowd_grant", 32'(grant), 32'h1);
    check("nowd_ready", 32'(m0_ready), 32'h0);
    check("nowd_flag", 32'(timeout_flag), 32'h0);
    m0_valid = 0;
    tick();
    check("nowd_drop_idle", 32'(grant), 32'h0);
`endif

    tick();
    m1_valid = 1; m1_addr = 32'h0400_0000;
    tick();
    m0_valid = 1;
    check("ar_grant_busy", 32'(grant), 32'h2);
    #1 s_ready = 1;
    #1;
    check("ar_m1_ready_pre", 32'(m1_ready), 32'h1);
    reset = 1;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_s_valid", 32'(s_valid), 32'h0);
    check("ar_m1_ready", 32'(m1_ready), 32'h0);
    #1 reset = 0; s_ready = 0;
    tick();
    check("ar_m0_first", 32'(grant), 32'h1);
    m0_valid = 0; m1_valid = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the native picorv32-style memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Sits between the CPU (master 0) and a second bus master such as a future DMA/loader (master 1) on one side, and the SoC address decoder/slave fabric on the other.
- Grants the single downstream bus to one master at a time and holds the grant until that transaction completes.
- Arbitration is round-robin or fixed-priority (parameter); optional watchdog aborts hung transactions.

Parameters:
- ROUND_ROBIN, 1, 1 = round-robin between masters; 0 = master 0 always wins ties.
- TIMEOUT_CYCLES, 255, cycles in a BUSY state without s_ready before abort (only with MEMARB_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_valid  in  1  master 0 request.
- m0_instr  in  1  master 0 instruction-fetch flag.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte write strobes (0 = read).
- m0_ready  out  1  master 0 completion strobe.
- m0_rdata  out  32  master 0 read data.
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, for master 1.
- s_valid  out  1  downstream request.
- s_instr  out  1  downstream instruction flag.
- s_addr  out  32  downstream address.
- s_wdata  out  32  downstream write data.
- s_wstrb  out  4  downstream strobes.
- s_ready  in  1  downstream completion.
- s_rdata  in  32  downstream read data.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 00 = idle.
- timeout_flag  out  1  sticky abort indicator.
- timeout_clr  in  1  clears timeout_flag.

Behaviour:
- Reset (async, active-high): state = IDLE, last_grant = m1, so m0 wins the first round-robin tie. grant = 00, s_valid = 0, s_instr = 0, s_addr/s_wdata = 0, s_wstrb = 0, m0_ready = m1_ready = 0, timeout_flag = 0, timeout counter = 0.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - Nothing is forwarded.
  - If exactly one mX_valid is high, go to BUSYX at the next edge.
  - If both are high: with ROUND_ROBIN=1, pick the master that is not last_grant; with ROUND_ROBIN=0, pick m0.
  - Arbitration latency is 1 cycle: the request appears on s_* the cycle after valid is first seen in IDLE.
- BUSYX:
  - s_valid = mX_valid.
  - s_instr/s_addr/s_wdata/s_wstrb = master X's signals, combinationally muxed. All s_* are 0 when not BUSY.
  - mX_ready = s_ready & s_valid. The other master's ready is forced 0.
  - m0_rdata = m1_rdata = s_rdata. Ready qualifies the data.
- Completion: on s_valid & s_ready, go to IDLE next edge and set last_grant = X. There is a mandatory 1-cycle IDLE turnaround between transactions, even for the same master.
- Protocol violation: if mX_valid drops while in BUSYX without s_ready, go to IDLE next edge. No ready is issued and last_grant is unchanged.
- s_ready while in IDLE is ignored.
- The losing master's valid is held pending. It is granted on the following IDLE cycle, so starvation is bounded to one transaction under round-robin.
- grant reflects the registered state: 01 in BUSY0, 10 in BUSY1.
- Mid-transaction reset: return to IDLE immediately. The downstream is abandoned, since the slaves share the same reset.
- timeout_clr has priority over a simultaneous abort: the flag stays 0.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on BUSY entry and increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES, that cycle drives s_valid = 0, mX_ready = 1 and mX_rdata = 32'hDEAD_BEEF.
  - timeout_flag is set (sticky until timeout_clr), and the state goes to IDLE next edge.
  - s_ready arriving in the same cycle as the abort wins: it is a normal completion and no flag is set.
- Without the macro: no counter, BUSY waits indefinitely, timeout_flag is tied 0 and timeout_clr is unused.

Decomposition:
- Package memarb_pkg:
  - state encoding (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2);
  - MEMARB_ABORT_DATA = 32'hDEAD_BEEF;
  - bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
- One sub-module, memarb_rr: combinational winner select from req[1:0], last_grant and ROUND_ROBIN, producing a one-hot next grant.
- The FSM, mux and watchdog stay in the top module.

Test Plan:
- Reset then m0 read: m0_valid=1, addr=0x0010_0000, s_ready after 3 cycles → s_addr=0x0010_0000 from cycle 2, grant=01, m0_ready a single pulse with rdata=s_rdata, back to IDLE.
- Simultaneous requests, ROUND_ROBIN=1: m0 and m1 held valid continuously, slave ready=1 each BUSY cycle → grant sequence 01,00,10,00,01,00,10.
- ROUND_ROBIN=0, same stimulus → grant sequence 01,00,01,00…; m1 only granted once m0_valid drops.
- m1 write 0x1234_5678, wstrb=4'b0011, to 0x0300_0000 while m0 idle → s_wstrb=0011, s_wdata=0x1234_5678, m0_ready stays 0 throughout.
- MEMARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready held 0 → m0_ready at BUSY cycle 8 with rdata=0xDEAD_BEEF, timeout_flag=1; timeout_clr pulse → 0.
- Async reset asserted mid-BUSY1 (between clock edges) → grant=00, s_valid=0, m1_ready=0 immediately; after release, a pending m0 request is granted first.
